nested_loop_seq: RTL and testbench

Parametrised timed nested-loop sequencer: executes an outer loop of `outer_n` iterations, each running an inner loop of `inner_n` iterations. One clock per loop-body step. The outer body increments `act2`; each inner body copies `act2` into `act1`. Adds a start/done handshake, runtime loop counts, hold/abort control and an auto-restart mode. Used as the reusable loop engine for timed-loop experiments and as a stimulus source for downstream counters.

---
 rtl/nested_loop_pkg.sv | 13 +
 rtl/nested_loop_seq_loop_counter.sv | 33 +++
 rtl/nested_loop_seq.sv | 139 +++++++++++++
 tb/tb_nested_loop_seq.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/nested_loop_pkg.sv
// Shared types and constants for the nested-loop sequencer.
package nested_loop_pkg;

   localparam int unsigned DEFAULT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OUTER = 2'd1,
      INNER = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/nested_loop_seq_loop_counter.sv
// W-bit index counter with synchronous clear, increment and a terminal flag at limit-1.
module loop_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         clr_i,
   input  logic         inc_i,
   input  logic [W-1:0] limit_i,
   output logic [W-1:0] value_o,
   output logic         last_o
);

   logic [W-1:0] value_q, value_d;
   logic [W-1:0] limit_m1;

   assign limit_m1 = limit_i - {{(W-1){1'b0}}, 1'b1};

   always_comb begin
      value_d = value_q;
      if (clr_i)      value_d = '0;
      else if (inc_i) value_d = value_q + {{(W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) value_q <= '0;
      else          value_q <= value_d;
   end

   assign value_o = value_q;
   assign last_o  = (value_q == limit_m1);

endmodule

// File: rtl/nested_loop_seq.sv
// Timed nested-loop sequencer: outer body bumps act2, each inner body copies act2 into act1.
//
// state | meaning
// IDLE  | waiting for start; act1/act2 hold last results
// OUTER | one cycle per outer iteration, act2 increments
// INNER | one cycle per inner iteration, act1 <= act2
// DONE  | single completion cycle, optional auto-restart
module nested_loop_seq
   import nested_loop_pkg::*;
#(
   parameter int unsigned W = DEFAULT_W
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         start_i,
   input  logic [W-1:0] outer_n_i,
   input  logic [W-1:0] inner_n_i,
   input  logic         auto_restart_i,
   input  logic         hold_i,
   input  logic         abort_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         outer_stb_o,
   output logic         inner_stb_o,
   output logic [W-1:0] x_o,
   output logic [W-1:0] y_o,
   output logic [W-1:0] act1_o,
   output logic [W-1:0] act2_o
);

   state_e       state_q, state_d;
   logic [W-1:0] outer_n_q, outer_n_d;
   logic [W-1:0] inner_n_q, inner_n_d;
   logic [W-1:0] act1_q, act1_d;
   logic [W-1:0] act2_q, act2_d;

   logic         run;
   logic         accept, restart, next_x, zero_l, zero_in;
   logic         x_clr, x_inc, y_clr, y_inc, x_last, y_last;
   logic [W-1:0] x_val, y_val;

   assign run     = !abort_i && !hold_i;
   assign accept  = (state_q == IDLE) && start_i;
   assign restart = (state_q == DONE) && auto_restart_i;
   assign next_x  = (state_q == INNER) && y_last && !x_last;
   assign zero_l  = (outer_n_q == '0) || (inner_n_q == '0);
   assign zero_in = (outer_n_i == '0) || (inner_n_i == '0);

   // abort wins over hold and start; hold freezes everything else
   always_comb begin
      state_d = state_q;
      if (abort_i) begin
         state_d = IDLE;
      end else if (!hold_i) begin
         unique case (state_q)
            IDLE:  if (start_i) state_d = zero_in ? DONE : OUTER;
            OUTER: state_d = INNER;
            INNER: if (y_last) state_d = x_last ? DONE : OUTER;
            DONE:  state_d = auto_restart_i ? (zero_l ? DONE : OUTER) : IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      outer_n_d = outer_n_q;
      inner_n_d = inner_n_q;
      act1_d    = act1_q;
      act2_d    = act2_q;
      if (run) begin
         if (accept) begin
            outer_n_d = outer_n_i;
            inner_n_d = inner_n_i;
         end
         if (accept || restart) begin
            act1_d = '0;
            act2_d = '0;
         end else if (state_q == OUTER) begin
            act2_d = act2_q + {{(W-1){1'b0}}, 1'b1};
         end else if (state_q == INNER) begin
            act1_d = act2_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         outer_n_q <= '0;
         inner_n_q <= '0;
         act1_q    <= '0;
         act2_q    <= '0;
      end else begin
         state_q   <= state_d;
         outer_n_q <= outer_n_d;
         inner_n_q <= inner_n_d;
         act1_q    <= act1_d;
         act2_q    <= act2_d;
      end
   end

   assign x_clr = abort_i || (!hold_i && (accept || restart));
   assign x_inc = run && next_x;
   assign y_clr = abort_i || (!hold_i && (accept || restart || (state_q == OUTER) || next_x));
   assign y_inc = run && (state_q == INNER) && !y_last;

   loop_counter #(.W(W)) u_x_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (x_clr),
      .inc_i   (x_inc),
      .limit_i (outer_n_q),
      .value_o (x_val),
      .last_o  (x_last)
   );

   loop_counter #(.W(W)) u_y_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (y_clr),
      .inc_i   (y_inc),
      .limit_i (inner_n_q),
      .value_o (y_val),
      .last_o  (y_last)
   );

   always_comb begin
      busy_o      = (state_q != IDLE);
      done_o      = (state_q == DONE);
      outer_stb_o = (state_q == OUTER) && !hold_i;
      inner_stb_o = (state_q == INNER) && !hold_i;
   end

   assign x_o    = x_val;
   assign y_o    = y_val;
   assign act1_o = act1_q;
   assign act2_o = act2_q;

endmodule

// File: tb/tb_nested_loop_seq.sv
// Directed bench for nested_loop_seq: reset, full runs, zero count, hold, abort, auto-restart.
module tb_nested_loop_seq;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] outer_n = '0;
   logic [W-1:0] inner_n = '0;
   logic         auto_restart = 1'b0;
   logic         hold = 1'b0;
   logic         abort = 1'b0;
   logic         busy, done, outer_stb, inner_stb;
   logic [W-1:0] x, y, act1, act2;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int n_o, n_i;
   logic [W-1:0] snap_y, snap_a1, snap_a2;
   int done_seen;

   always #5 clk = ~clk;

   nested_loop_seq #(.W(W)) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .start_i        (start),
      .outer_n_i      (outer_n),
      .inner_n_i      (inner_n),
      .auto_restart_i (auto_restart),
      .hold_i         (hold),
      .abort_i        (abort),
      .busy_o         (busy),
      .done_o         (done),
      .outer_stb_o    (outer_stb),
      .inner_stb_o    (inner_stb),
      .x_o            (x),
      .y_o            (y),
      .act1_o         (act1),
      .act2_o         (act2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   // accept a start on the next edge; afterwards cyc counts cycles since that edge
   task automatic run_start(input logic [W-1:0] o, input logic [W-1:0] i, input logic ar);
      outer_n = o;
      inner_n = i;
      auto_restart = ar;
      start = 1'b1;
      step();
      start = 1'b0;
      outer_n = 8'd77;
      inner_n = 8'd33;
      cyc = 1;
   endtask

   task automatic wait_done(input int limit);
      n_o = 0;
      n_i = 0;
      while (!done && cyc < limit) begin
         n_o += int'(outer_stb);
         n_i += int'(inner_stb);
         step();
      end
   endtask

   initial begin
      @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_outs", {8'd0, x, y, act1}, 32'd0);
      rst_n = 1'b1;
      step();

      // reset mid-run
      run_start(8'd10, 8'd10, 1'b0);
      repeat (49) step();
      chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_all_zero",
          {20'd0, busy, done, outer_stb, inner_stb, x | y | act1 | act2}, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      done_seen = 0;
      repeat (10) begin
         step();
         done_seen += int'(done) + int'(busy);
      end
      chk("rst_idle_after", done_seen, 32'd0);

      // defaults 10x10
      run_start(8'd10, 8'd10, 1'b0);
      chk("d10_first_outer_stb", {31'd0, outer_stb}, 32'd1);
      wait_done(400);
      chk("d10_done_cycle", cyc, 32'd111);
      chk("d10_outer_stbs", n_o, 32'd10);
      chk("d10_inner_stbs", n_i, 32'd100);
      chk("d10_final", {x, y, act1, act2}, {8'd9, 8'd9, 8'd10, 8'd10});
      step();
      chk("d10_idle_after", {30'd0, busy, done}, 32'd0);
      chk("d10_acts_kept", {16'd0, act1, act2}, {16'd0, 8'd10, 8'd10});

      // zero inner count
      run_start(8'd3, 8'd0, 1'b0);
      chk("z_done_k1", {28'd0, busy, done, outer_stb, inner_stb}, 32'b1100);
      chk("z_act2", {24'd0, act2}, 32'd0);
      step();
      chk("z_idle", {30'd0, busy, done}, 32'd0);

      // 2x2 with a 5-cycle hold in INNER
      run_start(8'd2, 8'd2, 1'b0);
      step();
      chk("h_in_inner", {24'd0, y, act1, act2} & 32'h00FF_FFFF, {8'd0, 8'd0, 8'd0, 8'd1});
      hold = 1'b1;
      #1;
      chk("h_stb_gated", {30'd0, inner_stb, busy}, 32'b01);
      snap_y = y; snap_a1 = act1; snap_a2 = act2;
      repeat (5) step();
      chk("h_frozen", {8'd0, y, act1, act2}, {8'd0, snap_y, snap_a1, snap_a2});
      chk("h_stb_still_low", {31'd0, inner_stb}, 32'd0);
      hold = 1'b0;
      wait_done(100);
      chk("h_done_cycle", cyc, 32'd12);
      chk("h_final", {x, y, act1, act2}, {8'd1, 8'd1, 8'd2, 8'd2});
      step();

      // abort together with hold and start at cycle 20
      run_start(8'd10, 8'd10, 1'b0);
      repeat (19) step();
      chk("a_pre_act2", {24'd0, act2}, 32'd2);
      abort = 1'b1; hold = 1'b1; start = 1'b1; outer_n = 8'd5; inner_n = 8'd5;
      step();
      chk("a_idle", {30'd0, busy, done}, 32'd0);
      chk("a_idx_clr_acts_kept", {x, y, act1, act2}, {8'd0, 8'd0, 8'd2, 8'd2});
      abort = 1'b0; hold = 1'b0; start = 1'b0;
      step();
      chk("a_start_ignored", {22'd0, busy, done, act2}, {24'd0, 8'd2});

      // 255x1 auto-restart
      run_start(8'd255, 8'd1, 1'b1);
      wait_done(1200);
      chk("ar_done_cycle", cyc, 32'd511);
      chk("ar_final", {x, y, act1, act2}, {8'd254, 8'd0, 8'd255, 8'd255});
      step();
      chk("ar_restart_outer", {29'd0, busy, done, outer_stb}, 32'b101);
      chk("ar_cleared", {16'd0, x, act2}, 32'd0);
      step();
      chk("ar_second_inner", {23'd0, inner_stb, act2}, {23'd0, 1'b1, 8'd1});
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("ar_abort_idle", {31'd0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
